// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard front end for the snake game: decodes arrow/WASD scan codes into a 2-bit direction.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat make codes for keys already held.
module ps2_dir_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic [3:0] key_held,
    output logic       frame_err
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rxState_t;

    logic              clkSync1_q, clkSync2_q;
    logic              datSync1_q, datSync2_q;
    logic              filtClk_q, filtClk_d;
    logic [FILT_W-1:0] filtCnt_q, filtCnt_d;
    logic              fall_q, fall_d;

    rxState_t          state_q;
    logic [2:0]        bitCnt_q;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic [TO_W-1:0]   toCnt_q;
    logic [7:0]        rxByte_q;
    logic              byteValid_q;
    logic              frameErr_q;

    logic              ext_q, brk_q;
    logic [1:0]        dir_q;
    logic              dirValid_q;
    logic [3:0]        keyHeld_q;

    logic              keyHit;
    logic [1:0]        keyCode;
    logic [3:0]        keyOneHot;
    logic              repeatMake;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clkSync1_q <= 1'b1;
            clkSync2_q <= 1'b1;
            datSync1_q <= 1'b1;
            datSync2_q <= 1'b1;
        end else begin
            clkSync1_q <= ps2_clk;
            clkSync2_q <= clkSync1_q;
            datSync1_q <= ps2_dat;
            datSync2_q <= datSync1_q;
        end
    end

    // The filtered level flips only after FILTER_LEN disagreeing samples in a row.
    always_comb begin
        filtClk_d = filtClk_q;
        filtCnt_d = '0;
        if (clkSync2_q != filtClk_q) begin
            if (filtCnt_q == FILT_LAST) begin
                filtClk_d = clkSync2_q;
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
    end

    assign fall_d = filtClk_q & ~filtClk_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            filtClk_q <= 1'b1;
            filtCnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            filtClk_q <= filtClk_d;
            filtCnt_q <= filtCnt_d;
            fall_q    <= fall_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            toCnt_q     <= '0;
            rxByte_q    <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            if (state_q == IDLE || fall_q) begin
                toCnt_q <= '0;
            end else begin
                toCnt_q <= toCnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (fall_q && !datSync2_q) begin
                        state_q  <= DATA;
                        bitCnt_q <= '0;
                    end
                end
                DATA: begin
                    if (fall_q) begin
                        shift_q  <= {datSync2_q, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 1'b1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall_q) begin
                        parity_q <= datSync2_q;
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    if (fall_q) begin
                        if (datSync2_q && (^{shift_q, parity_q})) begin
                            rxByte_q    <= shift_q;
                            byteValid_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A fall pulse in the expiry cycle keeps the frame alive.
            if (state_q != IDLE && !fall_q && toCnt_q == TO_LAST) begin
                state_q    <= IDLE;
                frameErr_q <= 1'b1;
                toCnt_q    <= '0;
            end
        end
    end

    always_comb begin
        keyHit  = 1'b0;
        keyCode = 2'd0;
        if (ext_q) begin
            case (rxByte_q)
                8'h6B: begin keyHit = 1'b1; keyCode = 2'd0; end
                8'h74: begin keyHit = 1'b1; keyCode = 2'd1; end
                8'h75: begin keyHit = 1'b1; keyCode = 2'd2; end
                8'h72: begin keyHit = 1'b1; keyCode = 2'd3; end
                default: keyHit = 1'b0;
            endcase
        end else begin
            case (rxByte_q)
                8'h1C: begin keyHit = 1'b1; keyCode = 2'd0; end
                8'h23: begin keyHit = 1'b1; keyCode = 2'd1; end
                8'h1D: begin keyHit = 1'b1; keyCode = 2'd2; end
                8'h1B: begin keyHit = 1'b1; keyCode = 2'd3; end
                default: keyHit = 1'b0;
            endcase
        end
    end

    assign keyOneHot = 4'b0001 << keyCode;

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign repeatMake = keyHeld_q[keyCode];
`else
    assign repeatMake = 1'b0;
`endif

    // Prefix bytes only set flags; any other byte consumes and clears them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            dir_q      <= 2'd1;
            dirValid_q <= 1'b0;
            keyHeld_q  <= '0;
        end else begin
            dirValid_q <= 1'b0;
            if (byteValid_q) begin
                case (rxByte_q)
                    8'hE0: ext_q <= 1'b1;
                    8'hF0: brk_q <= 1'b1;
                    default: begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                        if (keyHit) begin
                            if (brk_q) begin
                                keyHeld_q <= keyHeld_q & ~keyOneHot;
                            end else begin
                                keyHeld_q <= keyHeld_q | keyOneHot;
                                if (!repeatMake) begin
                                    dir_q      <= keyCode;
                                    dirValid_q <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign dir       = dir_q;
    assign dir_valid = dirValid_q;
    assign key_held  = keyHeld_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Scoreboard bench for ps2_dir_decoder: frames are bit-banged on the PS/2 lines and the
// expected dir_valid / frame_err pulses are queued with their exact arrival cycle.
`timescale 1ns/1ps
module tb_ps2_dir_decoder;

    localparam int FILTER_LEN = 8;
    // Two synchronizer stages plus the filter delay the fall pulse; the receiver and decoder add one each.
    localparam int FALL_LAT  = 2 + FILTER_LEN;
    localparam int ERR_LAT   = FALL_LAT + 1;
    localparam int VALID_LAT = FALL_LAT + 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [1:0] dir;
    logic       dir_valid;
    logic [3:0] key_held;
    logic       frame_err;

    typedef struct {
        logic [1:0] kind;
        logic [1:0] dir;
        int         cyc;
        string      tag;
    } expEvent_t;

    expEvent_t expQ[$];
    int cyc = 0;
    int checkCount = 0;
    int failCount = 0;

    ps2_dir_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(50000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .dir       (dir),
        .dir_valid (dir_valid),
        .key_held  (key_held),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [1:0] kind, input logic [1:0] d, input int when, input string tag);
        expEvent_t e;
        e.kind = kind;
        e.dir  = d;
        e.cyc  = when;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    // kind 2'b01 = dir_valid pulse, 2'b10 = frame_err pulse, 2'b00 = nothing expected.
    task automatic applyStimulus(input logic [7:0] data, input bit badParity, input int half,
                                 input int nBits, input logic [1:0] expKind, input logic [1:0] expDir,
                                 input string tag);
        logic [10:0] frame;
        logic        par;
        par = ~^data;
        if (badParity) par = ~par;
        frame = {1'b1, par, data, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            ps2_dat = frame[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && expKind != 2'b00) begin
                pushExpect(expKind, expDir, cyc + ((expKind == 2'b01) ? VALID_LAT : ERR_LAT), tag);
            end
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            checkOutput({tag, "_missing"}, expQ.size(), 0);
            expQ.delete();
        end
    endtask

    always @(negedge clk) begin
        if (resetn && (dir_valid || frame_err)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse", {30'd0, frame_err, dir_valid}, 0);
            end else begin
                expEvent_t e;
                e = expQ.pop_front();
                checkOutput({e.tag, "_kind"}, {30'd0, frame_err, dir_valid}, {30'd0, e.kind});
                if (e.kind == 2'b01) checkOutput({e.tag, "_dir"}, {30'd0, dir}, {30'd0, e.dir});
                if (e.cyc >= 0) checkOutput({e.tag, "_latency"}, cyc, e.cyc);
            end
        end
    end

    initial begin
        repeat (98000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        failCount++;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("reset_dir", {30'd0, dir}, 1);
        checkOutput("reset_key_held", {28'd0, key_held}, 0);
        checkOutput("reset_dir_valid", {31'd0, dir_valid}, 0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 0);

        // Extended up arrow at a 10 us bit period.
        applyStimulus(8'hE0, 1'b0, 250, 11, 2'b00, 2'd0, "ext_prefix");
        applyStimulus(8'h75, 1'b0, 250, 11, 2'b01, 2'd2, "up_make");
        waitDrain("up_make");
        checkOutput("up_key_held", {28'd0, key_held}, 32'h4);

        applyStimulus(8'hE0, 1'b0, 50, 11, 2'b00, 2'd0, "brk_ext");
        applyStimulus(8'hF0, 1'b0, 50, 11, 2'b00, 2'd0, "brk_f0");
        applyStimulus(8'h75, 1'b0, 50, 11, 2'b00, 2'd0, "up_break");
        waitDrain("up_break");
        checkOutput("break_key_held", {28'd0, key_held}, 0);
        checkOutput("break_dir", {30'd0, dir}, 2);

        applyStimulus(8'h1C, 1'b1, 50, 11, 2'b10, 2'd0, "bad_parity");
        waitDrain("bad_parity");
        checkOutput("bad_parity_dir", {30'd0, dir}, 2);
        applyStimulus(8'h1C, 1'b0, 50, 11, 2'b01, 2'd0, "a_make");
        waitDrain("a_make");
        checkOutput("a_key_held", {28'd0, key_held}, 32'h1);

        applyStimulus(8'h55, 1'b0, 50, 5, 2'b00, 2'd0, "truncated");
        pushExpect(2'b10, 2'd0, -1, "timeout");
        repeat (55000) @(negedge clk);
        waitDrain("timeout");
        applyStimulus(8'h23, 1'b0, 50, 11, 2'b01, 2'd1, "d_make");
        waitDrain("d_make");
        checkOutput("d_key_held", {28'd0, key_held}, 32'h3);

        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("glitch_key_held", {28'd0, key_held}, 32'h3);
        checkOutput("glitch_dir", {30'd0, dir}, 1);

        applyStimulus(8'h1D, 1'b0, 50, 11, 2'b01, 2'd2, "w_make1");
        waitDrain("w_make1");
`ifdef PS2_TYPEMATIC_FILTER_EN
        applyStimulus(8'h1D, 1'b0, 50, 11, 2'b00, 2'd2, "w_make2");
`else
        applyStimulus(8'h1D, 1'b0, 50, 11, 2'b01, 2'd2, "w_make2");
`endif
        waitDrain("w_make2");
        checkOutput("w_key_held", {28'd0, key_held}, 32'h7);

        applyStimulus(8'h1B, 1'b0, 50, 6, 2'b00, 2'd0, "partial");
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("midreset_dir", {30'd0, dir}, 1);
        checkOutput("midreset_key_held", {28'd0, key_held}, 0);
        checkOutput("midreset_dir_valid", {31'd0, dir_valid}, 0);
        checkOutput("midreset_frame_err", {31'd0, frame_err}, 0);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (50) @(negedge clk);
        applyStimulus(8'h1B, 1'b0, 50, 11, 2'b01, 2'd3, "s_make");
        waitDrain("s_make");
        checkOutput("s_key_held", {28'd0, key_held}, 32'h8);

        repeat (50) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
- Upstream input stage for the snake game; replaces the switch-based direction reader.
- Receives PS/2 keyboard frames, decodes arrow-key and WASD scan codes, and outputs the 2-bit direction code the control FSM consumes.
- Output encoding: 0 = left, 1 = right, 2 = up, 3 = down.
- dir is held between key presses; dir_valid marks each accepted press.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples needed before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz.
- resetn  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous.
- ps2_dat  input  1  raw PS/2 data line, asynchronous.
- dir  output  2  last accepted direction; 0 left, 1 right, 2 up, 3 down.
- dir_valid  output  1  one-cycle pulse when dir is updated by a make code.
- key_held  output  4  held-key flags; bit0 left, bit1 right, bit2 up, bit3 down.
- frame_err  output  1  one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
- Clock and reset: resetn is asynchronous, active-low; clock is clk. All state updates on posedge clk.
- Reset values: dir = 2'd1 (right, matching the control FSM reset direction); dir_valid = 0; key_held = 0; frame_err = 0; receiver in IDLE; prefix flags cleared; filter counter = 0; timeout counter = 0. Reset asserted mid-frame discards the partial frame.
- Synchronizer: each of ps2_clk and ps2_dat passes through two flip-flops.
- Clock filter:
  - Filtered clock level resets to 1.
  - It changes only after FILTER_LEN consecutive synchronized samples differ from the current filtered level.
  - Any matching sample restarts the count.
- Edge detect: a filtered 1->0 transition yields a one-cycle fall pulse. The synchronized data bit is sampled in that cycle.
- Receiver FSM states:
  - IDLE: on fall with data 0, go to DATA with bit count 0. On fall with data 1, ignore and stay in IDLE.
  - DATA: shift data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: on fall, check stop bit = 1 and odd parity (the 8 data bits plus the parity bit contain an odd number of ones). If both pass, raise internal byte_valid next cycle. Otherwise pulse frame_err and drop the byte. Return to IDLE in both cases.
- Timeout: in any state other than IDLE, count clk cycles since the last fall pulse.
  - On reaching TIMEOUT_CYCLES: go to IDLE, pulse frame_err, drop the partial byte.
  - The counter clears on every fall pulse and whenever in IDLE.
- Byte decoder, acting on byte_valid:
  - 8'hE0: set ext.
  - 8'hF0: set brk.
  - Any other byte: decode, then clear both ext and brk.
- Direction code map:
  - With ext = 1: 6B left, 74 right, 75 up, 72 down.
  - With ext = 0: 1C left (A), 23 right (D), 1D up (W), 1B down (S).
  - Any other code: no effect beyond clearing the flags.
- Make code (brk = 0) for a mapped key:
  - key_held bit is set.
  - dir is loaded and dir_valid pulses.
  - Latency: dir and dir_valid update exactly 2 clk cycles after the stop-bit fall pulse.
- Break code (brk = 1) for a mapped key: key_held bit is cleared. dir and dir_valid are unchanged.
- No reversal filtering: opposite directions are passed through. The control FSM rejects reversals.
- Simultaneous events: fall pulse and timeout expiry in the same cycle means the fall wins and the counter clears. frame_err never suppresses a decode already in flight.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined: a make code whose key_held bit is already 1 produces no dir_valid and no dir update. This suppresses keyboard auto-repeat.
- Undefined: every make code, including auto-repeats, updates dir and pulses dir_valid.

Test Plan:
- Reset, then idle lines at 1 -> dir = 1, dir_valid = 0, key_held = 0, frame_err = 0 indefinitely.
- Frames E0, 75 (10 us PS/2 bit period) -> dir = 2, one dir_valid pulse exactly 2 cycles after the 75 stop-bit fall, key_held = 4'b0100.
- Frames E0, F0, 75 -> key_held = 0, dir stays 2, no dir_valid.
- Frame 1C with a corrupted parity bit -> frame_err pulse, dir unchanged, no dir_valid. A following good 1C -> dir = 0.
- Frame truncated after 4 data bits, then 1.1 ms quiet -> frame_err pulse, FSM in IDLE. A following good 23 -> dir = 1 with dir_valid.
- 3-cycle glitch low on ps2_clk during idle -> no fall pulse, no state change. Repeated make 1D twice -> two dir_valid pulses without PS2_TYPEMATIC_FILTER_EN, one pulse with it. resetn low mid-frame -> all outputs return to reset values immediately.
